// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 window generator.
package filter_pkg;

  // Frame sequencing: waiting for a frame, streaming it, draining the last rows.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsm_t;

  // Bit positions inside the 4-bit bypass (edge) flag vector.
  localparam int BYP_TOP   = 0;
  localparam int BYP_BOT   = 1;
  localparam int BYP_LEFT  = 2;
  localparam int BYP_RIGHT = 3;

endpackage

// File: rtl/filter_line_buffer.sv
// One line of pixel storage: simple dual-port RAM with a registered read.
// Contents are intentionally not reset; the window edge flags hide stale data.
module filter_line_buffer #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 2048,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port plus one-cycle registered read (old data on address collision).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/filter_3x3_window.sv
// Raster-to-3x3-window generator with two cascaded line buffers.
// Input handshake: a pixel transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends on the FSM state only and in_valid
// may be held across cycles where in_ready is low. The output has no ready:
// out_valid marks each cycle that carries a window.
module filter_3x3_window
  import filter_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int MAX_WIDTH = 2048,
  parameter int CWIDTH    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CWIDTH-1:0] img_width,
  input  logic [CWIDTH-1:0] img_height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic [3:0]        bypass,
  output logic [DWIDTH-1:0] data_a,
  output logic [DWIDTH-1:0] data_b,
  output logic [DWIDTH-1:0] data_c,
  output logic [DWIDTH-1:0] data_d,
  output logic [DWIDTH-1:0] data_e,
  output logic [DWIDTH-1:0] data_f,
  output logic [DWIDTH-1:0] data_g,
  output logic [DWIDTH-1:0] data_h,
  output logic [DWIDTH-1:0] data_i,
  output logic              cfg_err
);

  localparam int              AWIDTH = $clog2(MAX_WIDTH);
  localparam logic [CWIDTH:0] MAX_W  = (CWIDTH+1)'(MAX_WIDTH);
  localparam logic [CWIDTH-1:0] ONE  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] TWO  = CWIDTH'(2);

  fsm_t              state;
  logic [CWIDTH-1:0] width_q, height_q;
  logic [CWIDTH-1:0] col_q, row_q;     // raster position of the next input pixel
  logic [CWIDTH-1:0] ccol_q, crow_q;   // centre position of the next window
  logic [CWIDTH-1:0] fcnt_q;

  logic              accept, size_ok, start, reject, run_px, last_px;
  logic              flush_cyc, produce, wr_px, shift;
  logic [AWIDTH-1:0] idx_addr;
  logic [3:0]        byp_now;

  logic [DWIDTH-1:0] lb1_rd, lb2_rd;

  // Stage 1: aligned with the line-buffer read data.
  logic              s1_shift, s1_valid, s1_sof, s1_eof, s1_wr;
  logic [3:0]        s1_byp;
  logic [DWIDTH-1:0] s1_data;
  logic [AWIDTH-1:0] s1_addr;

  // Handshake decode, frame control strobes and centre edge flags.
  always_comb begin
    in_ready  = (state != FLUSH);
    accept    = in_valid && in_ready;
    size_ok   = (img_width >= TWO) && ({1'b0, img_width} <= MAX_W) && (img_height >= TWO);
    start     = accept && in_sof && size_ok;
    reject    = accept && in_sof && !size_ok;
    run_px    = accept && !in_sof && (state == RUN);
    last_px   = run_px && (row_q == height_q - ONE) && (col_q == width_q - ONE);
    flush_cyc = (state == FLUSH);
    // A window exists once the bottom-right pixel of the first full window is in.
    produce   = flush_cyc || (run_px && ((row_q >= TWO) || ((row_q == ONE) && (col_q >= ONE))));
    wr_px     = start || run_px;
    shift     = wr_px || flush_cyc;
    idx_addr  = start ? '0 : col_q[AWIDTH-1:0];
    byp_now            = '0;
    byp_now[BYP_TOP]   = (crow_q == '0);
    byp_now[BYP_BOT]   = (crow_q == height_q - ONE);
    byp_now[BYP_LEFT]  = (ccol_q == '0);
    byp_now[BYP_RIGHT] = (ccol_q == width_q - ONE);
  end

  // Buffer 1 holds the previous line, buffer 2 the line before it.
  filter_line_buffer #(.DWIDTH(DWIDTH), .DEPTH(MAX_WIDTH), .AWIDTH(AWIDTH)) u_lb1 (
    .clk     (clk),
    .wr_en   (wr_px),
    .wr_addr (idx_addr),
    .wr_data (in_data),
    .rd_addr (idx_addr),
    .rd_data (lb1_rd)
  );

  filter_line_buffer #(.DWIDTH(DWIDTH), .DEPTH(MAX_WIDTH), .AWIDTH(AWIDTH)) u_lb2 (
    .clk     (clk),
    .wr_en   (s1_wr),
    .wr_addr (s1_addr),
    .wr_data (lb1_rd),
    .rd_addr (idx_addr),
    .rd_data (lb2_rd)
  );

  // Frame FSM with input raster counters, flush counter and centre counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ccol_q   <= '0;
      crow_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      if (start) begin
        // Index 0 is the pixel being accepted now; a restart drops pending windows.
        state    <= RUN;
        width_q  <= img_width;
        height_q <= img_height;
        col_q    <= ONE;
        row_q    <= '0;
        ccol_q   <= '0;
        crow_q   <= '0;
      end else if (reject) begin
        state <= IDLE;
      end else begin
        case (state)
          RUN: begin
            if (run_px) begin
              if (col_q == width_q - ONE) begin
                col_q <= '0;
                row_q <= row_q + ONE;
              end else begin
                col_q <= col_q + ONE;
              end
              if (last_px) begin
                state  <= FLUSH;
                fcnt_q <= '0;
              end
            end
          end
          FLUSH: begin
            // The column counter keeps running so the buffers are read in order.
            col_q  <= (col_q == width_q - ONE) ? '0 : col_q + ONE;
            fcnt_q <= fcnt_q + ONE;
            if (fcnt_q == width_q) state <= IDLE;
          end
          default: ;
        endcase
        if (produce) begin
          if (ccol_q == width_q - ONE) begin
            ccol_q <= '0;
            crow_q <= crow_q + ONE;
          end else begin
            ccol_q <= ccol_q + ONE;
          end
        end
      end
    end
  end

  // Stage 1: delay control and the new bottom pixel to meet the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_shift <= 1'b0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_byp   <= '0;
      s1_data  <= '0;
      s1_wr    <= 1'b0;
      s1_addr  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      s1_shift <= shift;
      s1_valid <= produce;
      s1_sof   <= produce && (crow_q == '0) && (ccol_q == '0);
      s1_eof   <= produce && (crow_q == height_q - ONE) && (ccol_q == width_q - ONE);
      s1_byp   <= produce ? byp_now : 4'b0000;
      s1_data  <= in_data;
      s1_wr    <= wr_px;
      s1_addr  <= idx_addr;
      cfg_err  <= reject;
    end
  end

  // Stage 2: three column shift registers form the window; flags registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      bypass    <= '0;
      data_a <= '0; data_b <= '0; data_c <= '0;
      data_d <= '0; data_e <= '0; data_f <= '0;
      data_g <= '0; data_h <= '0; data_i <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sof   <= s1_sof;
      out_eof   <= s1_eof;
      bypass    <= s1_byp;
      if (s1_shift) begin
        data_a <= data_b; data_b <= data_c; data_c <= lb2_rd;
        data_d <= data_e; data_e <= data_f; data_f <= lb1_rd;
        data_g <= data_h; data_h <= data_i; data_i <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_filter_3x3_window.sv
// Bench for filter_3x3_window: random frames against a neighbourhood model.
module tb_filter_3x3_window;

  localparam int DW   = 16;
  localparam int MAXW = 2048;
  localparam int CW   = 12;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [CW-1:0] img_width = '0, img_height = '0;
  logic          in_valid = 1'b0, in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_sof, out_eof, cfg_err;
  logic [3:0]    bypass;
  logic [DW-1:0] data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h, data_i;

  filter_3x3_window #(.DWIDTH(DW), .MAX_WIDTH(MAXW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .img_width(img_width), .img_height(img_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .bypass(bypass),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d), .data_e(data_e),
    .data_f(data_f), .data_g(data_g), .data_h(data_h), .data_i(data_i), .cfg_err(cfg_err)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0]     tag;   // edge count after which the window must be visible
    logic            sof;
    logic            eof;
    logic [3:0]      byp;
    logic [8:0]      care;  // window positions that lie inside the image
    logic [9*DW-1:0] d;     // position j (a=0 .. i=8) at d[j*DW +: DW]
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] frame_pix [0:4095];
  int            cur_w = 0, cur_h = 0;
  int            checks = 0, failures = 0;
  int            exp_cfg = 0, cfg_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: the 3x3 neighbourhood of raster index m, positions outside the image not cared.
  function automatic exp_t make_exp(input int m, input int tag);
    exp_t e;
    int r, c, rr, cc, j;
    e = '0;
    r = m / cur_w;
    c = m % cur_w;
    e.tag    = 32'(tag);
    e.sof    = (m == 0);
    e.eof    = (m == cur_w * cur_h - 1);
    e.byp[0] = (r == 0);
    e.byp[1] = (r == cur_h - 1);
    e.byp[2] = (c == 0);
    e.byp[3] = (c == cur_w - 1);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        j  = (dr + 1) * 3 + (dc + 1);
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < cur_h && cc >= 0 && cc < cur_w) begin
          e.care[j] = 1'b1;
          e.d[j*DW +: DW] = frame_pix[rr * cur_w + cc];
        end
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t            e;
    logic [9*DW-1:0] act, mask;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && cfg_err) cfg_seen++;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window actual=valid expected=none at edge %0d", cyc);
        end else begin
          e    = exp_q.pop_front();
          act  = {data_i, data_h, data_g, data_f, data_e, data_d, data_c, data_b, data_a};
          mask = '0;
          for (int j = 0; j < 9; j++) if (e.care[j]) mask[j*DW +: DW] = '1;
          chk("win_edge", cyc, int'(e.tag));
          chk("win_sof", int'(out_sof), int'(e.sof));
          chk("win_eof", int'(out_eof), int'(e.eof));
          chk("win_bypass", int'(bypass), int'(e.byp));
          chk_data("win_data", act & mask, e.d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel until accepted; returns the accepting edge number.
  task automatic send_px(input logic sof, input logic [DW-1:0] d, output int acc);
    logic rdy;
    int   t;
    t        = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_accept expected=accept at edge %0d", cyc);
        break;
      end
    end
    acc      = cyc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // mode 0 continuous, 1 valid pattern 1,0,0,1, 2 random gaps.
  task automatic send_frame(input int w, input int h, input int mode, input int abort_at,
                            input bit hold_next, input bit seq);
    int acc, last;
    cur_w = w;
    cur_h = h;
    for (int k = 0; k < w * h; k++)
      frame_pix[k] = seq ? DW'(k) : DW'($urandom_range(0, 65535));
    img_width  = CW'(w);
    img_height = CW'(h);
    last = 0;
    for (int n = 0; n < w * h; n++) begin
      if (n == abort_at) return;
      if (mode == 1 && (n % 2) == 1) idle(2);
      else if (mode == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      send_px(n == 0, frame_pix[n], acc);
      if (n >= w + 1) exp_q.push_back(make_exp(n - w - 1, acc + 1));
      last = acc;
    end
    for (int k = 0; k <= w; k++) exp_q.push_back(make_exp(w * h - w - 1 + k, last + 2 + k));
    in_valid = hold_next;
    in_sof   = hold_next;
    in_data  = DW'($urandom_range(0, 65535));
    for (int k = 0; k <= w; k++) begin
      chk("flush_ready_low", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    chk("flush_ready_high", int'(in_ready), 1);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_sof_eof"}, int'({out_sof, out_eof}), 0);
    chk({name, "_cfg_err"}, int'(cfg_err), 0);
    chk({name, "_bypass"}, int'(bypass), 0);
    chk({name, "_ready"}, int'(in_ready), 1);
    chk_data({name, "_data"},
             {data_i, data_h, data_g, data_f, data_e, data_d, data_c, data_b, data_a}, '0);
  endtask

  task automatic bad_size(input int w, input int h);
    int acc;
    img_width  = CW'(w);
    img_height = CW'(h);
    send_px(1'b1, DW'($urandom_range(0, 65535)), acc);
    exp_cfg++;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    idle(1);
    chk("cfg_err_clear", int'(cfg_err), 0);
    chk("cfg_ready_idle", int'(in_ready), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pixels without sof in IDLE are dropped.
    for (int k = 0; k < 3; k++) send_px(1'b0, DW'($urandom_range(0, 65535)), acc);

    // Rejected sizes.
    bad_size(1, 3);
    bad_size(4, 1);
    bad_size(MAXW + 1, 2);

    // 4x3 raster-index frame, continuous then with the 1,0,0,1 valid pattern.
    send_frame(4, 3, 0, -1, 1'b0, 1'b1);
    idle(3);
    send_frame(4, 3, 1, -1, 1'b0, 1'b1);
    idle(3);

    // Back-to-back 2x2 frames, next sof held during flush.
    send_frame(2, 2, 0, -1, 1'b1, 1'b0);
    send_frame(2, 2, 0, -1, 1'b0, 1'b0);
    idle(2);

    // Abort a 5x4 frame after 7 pixels, then a full 5x4 frame.
    send_frame(5, 4, 0, 7, 1'b0, 1'b0);
    send_frame(5, 4, 2, -1, 1'b0, 1'b0);
    idle(2);

    // Reset mid-RUN: outputs clear immediately, pending windows are lost.
    send_frame(4, 3, 0, 7, 1'b0, 1'b0);
    #4 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send_px(1'b0, DW'($urandom_range(0, 65535)), acc);
    idle(3);
    send_frame(3, 3, 2, -1, 1'b0, 1'b0);

    // Random sizes and gaps.
    for (int f = 0; f < 6; f++) begin
      send_frame(int'($urandom_range(2, 9)), int'($urandom_range(2, 6)), 2, -1,
                 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(2);

    // Widest line.
    send_frame(MAXW, 2, 0, -1, 1'b0, 1'b0);

    // Drain.
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    idle(4);
    chk("windows_drained", exp_q.size(), 0);
    chk("cfg_err_count", cfg_seen, exp_cfg);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_3x3_window.md
# filter_3x3_window

Raster-to-window generator that feeds the 3x3 low-pass mask. Accepts a pixel stream, stores the two previous lines in line buffers, and emits one 3x3 neighbourhood (pixels a..i) per input pixel, with the 4-bit bypass select that flags image edges. After the last input pixel it flushes internally so that exactly W*H windows leave per frame, in raster order of the centre pixel.

## Interface
- DWIDTH, 16: pixel width.
- MAX_WIDTH, 2048: maximum line length and line-buffer depth.
- CWIDTH, 12: width of the row and column counters and of the size inputs.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- img_width  in  CWIDTH  W, latched at the start-of-frame handshake.
- img_height  in  CWIDTH  H, latched at the start-of-frame handshake.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_sof  in  1  qualifies the first pixel of a frame.
- in_data  in  DWIDTH  input pixel.
- out_valid  out  1  window valid. There is no backpressure on this output.
- out_sof  out  1  first window of the frame (centre at 0,0).
- out_eof  out  1  last window of the frame (centre at H-1,W-1).
- bypass  out  4  bit0 top, bit1 bottom, bit2 left, bit3 right.
- data_a..data_i  out  DWIDTH each  window: a b c is the top row, d e f the middle row, g h i the bottom row; a/d/g is the left column; e is the centre.
- cfg_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Accept: in_valid && in_ready.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN: accept with in_sof, 2 ≤ W ≤ MAX_WIDTH and H ≥ 2. Latch W and H; this pixel is raster index 0.
  - IDLE, invalid size: pulse cfg_err, stay in IDLE, drop the pixel.
  - IDLE, accept without in_sof: pixel is dropped silently.
- RUN: raster index n (column counter, row counter) advances on each accept.
  - Once n ≥ W+1, each accept produces the window centred at index n−W−1.
  - Accepting index W*H−1 → FLUSH.
- FLUSH: in_ready=0 for exactly W+1 cycles. Each cycle produces one further window. Counter expiry → IDLE.
- in_sof accepted in RUN: abort the current frame and drop its pending windows. Re-run the IDLE size check and start a new frame at index 0. Windows already in the output pipeline still emerge.
- Line-buffer input data is not cleared on reset. Fill order guarantees no uninitialised pixel reaches an unbypassed window position.
- Window: three 3-deep column shift registers fed by {line buffer 2, line buffer 1, in_data}.
  - The column that wraps across a line end holds stale or next-line data. The bypass flags cover that column; the block does not mask it.
  - During FLUSH, the new bottom-row sample is don't-care. bit1 covers it.
- Bypass is computed from the centre's (row, col):
  - bit0 = (row == 0).
  - bit1 = (row == H−1).
  - bit2 = (col == 0).
  - bit3 = (col == W−1).
- out_sof is asserted with the centre at (0,0). out_eof is asserted with the centre at (H−1,W−1).

## Timing
- Latency: window outputs are registered. out_valid and all window and flag outputs appear 2 cycles after the producing accept or flush cycle: one cycle of line-buffer read, one cycle of output register.
- Input gaps (in_valid low) produce output gaps. Output order is unchanged.
- in_ready is combinational from state only: 1 in IDLE and RUN, 0 in FLUSH.
- Throughput: 1 window per cycle. Frames are separated by at least W+1 FLUSH cycles.
- Reset values:
  - FSM = IDLE, all counters = 0.
  - in_ready = 1.
  - out_valid = out_sof = out_eof = cfg_err = 0.
  - bypass = 0.
  - data_a..data_i = 0.
- Reset asserted mid-frame: everything above is restored asynchronously. The first frame after reset release needs a fresh in_sof.

## Structure
- Package filter_pkg:
  - enum fsm_t {IDLE, RUN, FLUSH}.
  - localparams for the bypass bit indices (BYP_TOP=0, BYP_BOT=1, BYP_LEFT=2, BYP_RIGHT=3).
- Sub-module filter_line_buffer: simple dual-port RAM, MAX_WIDTH × DWIDTH, 1-cycle registered read, write-first not required. Two instances in cascade: buffer 1 is written with in_data, buffer 2 with buffer 1's read data. Both use the column counter as address.

## Test plan
- 4x3 frame, pixel value = raster index, continuous valid → 12 windows. Centre (1,1): a..i = 0,1,2,4,5,6,8,9,10, bypass=0000. First window has out_sof and bypass=0101; the 12th has out_eof and bypass=1010. in_ready low exactly 5 cycles after the last accept.
- Same frame with in_valid toggled 1,0,0,1 repeating → identical window sequence. Each out_valid arrives 2 cycles after its producing accept.
- Back-to-back 2x2 frames: second in_sof presented during FLUSH is held off by in_ready=0 → 4 + 4 windows, no data mixing between frames.
- In a 5x4 frame, in_sof after 7 pixels → no windows for the aborted frame beyond those already in the pipeline; the new frame produces 20 windows.
- rst_n low for 1 cycle mid-RUN → all outputs 0 on the same edge. Pixels without in_sof are then dropped until the next in_sof.
- img_width=1 with in_sof → cfg_err pulse, no out_valid, state stays IDLE.
